// File: rtl/vedic64_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vedic64_seq_ctrl
//  Purpose  : Sequential 64x64 unsigned multiply controller. Time-shares one
//             external HWxHW multiplier over four partial-product steps and
//             accumulates them into a 4*HW-bit product, with valid/ready
//             handshakes on both the operand and result sides.
//  Revision : 1.0 - initial release
// ============================================================================
module vedic64_seq_ctrl #(
    parameter int HW       = 32,
    parameter int PIPE_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*HW-1:0] a_in,
    input  logic [2*HW-1:0] b_in,
    output logic [HW-1:0]   mul_a,
    output logic [HW-1:0]   mul_b,
    input  logic [2*HW-1:0] mul_p,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*HW-1:0] product,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P1   = 3'd2,
        S_P2   = 3'd3,
        S_P3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Last wait-counter value of a step: the cycle in which mul_p is valid.
    localparam logic [2:0] C_LAST = 3'(PIPE_LAT);

    state_t          r_state;
    logic [2*HW-1:0] r_a;
    logic [2*HW-1:0] r_b;
    logic [4*HW-1:0] r_acc;
    logic [2:0]      r_cnt;

    logic            w_step_end;
    logic [4*HW-1:0] w_p_ext;

    assign w_step_end = (r_cnt == C_LAST);
    assign w_p_ext    = {{(2*HW){1'b0}}, mul_p};
    assign busy       = (r_state != S_IDLE);

    // Controller FSM: operand capture, per-step multiplier drive, accumulation
    // and result handshake. mul_a/mul_b are set on the edge that enters a step
    // so they are stable for the whole step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        mul_a    <= a_in[HW-1:0];
                        mul_b    <= b_in[HW-1:0];
                        in_ready <= 1'b0;
                        r_state  <= S_P0;
                    end
                end
                S_P0: begin
                    if (w_step_end) begin
                        r_acc   <= r_acc + w_p_ext;
                        r_cnt   <= '0;
                        mul_a   <= r_a[2*HW-1:HW];
                        mul_b   <= r_b[HW-1:0];
                        r_state <= S_P1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_P1: begin
                    if (w_step_end) begin
                        r_acc   <= r_acc + (w_p_ext << HW);
                        r_cnt   <= '0;
                        mul_a   <= r_a[HW-1:0];
                        mul_b   <= r_b[2*HW-1:HW];
                        r_state <= S_P2;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_P2: begin
                    if (w_step_end) begin
                        r_acc   <= r_acc + (w_p_ext << HW);
                        r_cnt   <= '0;
                        mul_a   <= r_a[2*HW-1:HW];
                        mul_b   <= r_b[2*HW-1:HW];
                        r_state <= S_P3;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_P3: begin
                    if (w_step_end) begin
                        r_acc     <= r_acc + (w_p_ext << (2*HW));
                        product   <= r_acc + (w_p_ext << (2*HW));
                        out_valid <= 1'b1;
                        r_cnt     <= '0;
                        mul_a     <= '0;
                        mul_b     <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    // product holds its value after the handshake
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    mul_a     <= '0;
                    mul_b     <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vedic64_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vedic64_seq_ctrl
//  Purpose  : Self-checking bench for vedic64_seq_ctrl. Two instances: one with
//             a combinational multiplier (PIPE_LAT=0), one with a two-stage
//             registered multiplier (PIPE_LAT=2). A select bit routes shared
//             stimulus and observation to one instance at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vedic64_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic         in_valid;
    logic         out_ready;
    logic [63:0]  a_in;
    logic [63:0]  b_in;

    logic         in_ready0, out_valid0, busy0;
    logic [31:0]  mul_a0, mul_b0;
    logic [63:0]  mul_p0;
    logic [127:0] product0;

    logic         in_ready2, out_valid2, busy2;
    logic [31:0]  mul_a2, mul_b2;
    logic [63:0]  mul_p2;
    logic [127:0] product2;
    logic [63:0]  pipe1 = '0;
    logic [63:0]  pipe2 = '0;

    logic         w_in_ready, w_out_valid, w_busy;
    logic [31:0]  w_mul_a, w_mul_b;
    logic [127:0] w_product;

    int cmp_n  = 0;
    int fail_n = 0;

    always #5 clk = ~clk;

    // reference multipliers
    assign mul_p0 = 64'(mul_a0) * 64'(mul_b0);
    always @(posedge clk) begin
        pipe1 <= 64'(mul_a2) * 64'(mul_b2);
        pipe2 <= pipe1;
    end
    assign mul_p2 = pipe2;

    vedic64_seq_ctrl #(.HW(32), .PIPE_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(in_ready0),
        .a_in(a_in), .b_in(b_in),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
        .out_valid(out_valid0), .out_ready(out_ready & ~sel),
        .product(product0), .busy(busy0)
    );

    vedic64_seq_ctrl #(.HW(32), .PIPE_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(in_ready2),
        .a_in(a_in), .b_in(b_in),
        .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
        .out_valid(out_valid2), .out_ready(out_ready & sel),
        .product(product2), .busy(busy2)
    );

    assign w_in_ready  = sel ? in_ready2  : in_ready0;
    assign w_out_valid = sel ? out_valid2 : out_valid0;
    assign w_busy      = sel ? busy2      : busy0;
    assign w_mul_a     = sel ? mul_a2     : mul_a0;
    assign w_mul_b     = sel ? mul_b2     : mul_b0;
    assign w_product   = sel ? product2   : product0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s sel=%0d actual=%h required=%h t=%0t", nm, sel, act, exp, $time);
        end
    endtask

    // One full transaction: accept, step-by-step operand check, result check,
    // optional back-pressure of `hold` cycles, then the result handshake.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_,
                          input logic [127:0] exp, input int hold, input bit keep_valid);
        int pl;
        int n;
        int k;
        pl = sel ? 2 : 0;
        n  = 0;
        while (!w_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_idle", 128'(w_in_ready), 128'd1);
        chk("busy_idle", 128'(w_busy), 128'd0);
        in_valid  = 1'b1;
        a_in      = ta;
        b_in      = tb_;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
        for (int s = 0; s < 4 * (pl + 1); s++) begin
            k = s / (pl + 1);
            chk("mul_a_step", 128'(w_mul_a), 128'(k[0] ? ta[63:32] : ta[31:0]));
            chk("mul_b_step", 128'(w_mul_b), 128'((k >= 2) ? tb_[63:32] : tb_[31:0]));
            chk("in_ready_step", 128'(w_in_ready), 128'd0);
            chk("out_valid_step", 128'(w_out_valid), 128'd0);
            chk("busy_step", 128'(w_busy), 128'd1);
            @(posedge clk); #1;
        end
        chk("out_valid_rise", 128'(w_out_valid), 128'd1);
        chk("product", w_product, exp);
        chk("mul_a_done", 128'(w_mul_a), 128'd0);
        chk("mul_b_done", 128'(w_mul_b), 128'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("out_valid_hold", 128'(w_out_valid), 128'd1);
            chk("product_hold", w_product, exp);
            chk("in_ready_hold", 128'(w_in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_after_hs", 128'(w_out_valid), 128'd0);
        chk("in_ready_after_hs", 128'(w_in_ready), 128'd1);
        chk("busy_after_hs", 128'(w_busy), 128'd0);
        chk("product_kept", w_product, exp);
        out_ready = 1'b0;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
        int           hold;
        bit           keep;
        bit           sel;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  ra;
        logic [63:0]  rb;
        logic [127:0] rp;
        int           pl;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   128'hFFFFFFFFFFFFFFFE0000000000000001, 0, 1'b0, 1'b0};
        tbl[1] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
                   128'h00000000000000010000000000000000, 0, 1'b0, 1'b0};
        tbl[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   128'h0121FA00AD77D7422236D88FE5618CF0, 10, 1'b0, 1'b0};
        tbl[3] = '{64'd0, 64'd7, 128'd0, 0, 1'b1, 1'b0};
        tbl[4] = '{64'd7, 64'd0, 128'd0, 0, 1'b0, 1'b0};
        tbl[5] = '{64'd3, 64'd5, 128'd15, 2, 1'b0, 1'b1};

        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state, both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk("rst_in_ready", 128'(w_in_ready), 128'd1);
            chk("rst_out_valid", 128'(w_out_valid), 128'd0);
            chk("rst_product", w_product, 128'd0);
            chk("rst_mul_a", 128'(w_mul_a), 128'd0);
            chk("rst_mul_b", 128'(w_mul_b), 128'd0);
            chk("rst_busy", 128'(w_busy), 128'd0);
        end

        // directed table
        for (int i = 0; i < 6; i++) begin
            sel = tbl[i].sel;
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].hold, tbl[i].keep);
        end

        // reset while in P2, on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            pl  = sel ? 2 : 0;
            in_valid = 1'b1;
            a_in = 64'hFFFF_FFFF_FFFF_FFFF;
            b_in = 64'hFFFF_FFFF_FFFF_FFFF;
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (2 * (pl + 1)) @(posedge clk);
            #1;
            chk("in_p2_mul_b", 128'(w_mul_b), 128'hFFFF_FFFF);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("midrst_in_ready", 128'(w_in_ready), 128'd1);
            chk("midrst_out_valid", 128'(w_out_valid), 128'd0);
            chk("midrst_product", w_product, 128'd0);
            chk("midrst_mul_a", 128'(w_mul_a), 128'd0);
            chk("midrst_mul_b", 128'(w_mul_b), 128'd0);
            chk("midrst_busy", 128'(w_busy), 128'd0);
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                chk("no_spurious_result", 128'(w_out_valid), 128'd0);
            end
            out_ready = 1'b0;
        end

        // randomized transactions against a plain-arithmetic model
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 12; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (i == 0) ra = '1;
                if (i == 1) rb = 64'hFFFF_FFFF_0000_0000;
                rp = {64'd0, ra} * {64'd0, rb};
                run_op(ra, rb, rp, int'($urandom_range(0, 3)), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vedic64_seq_ctrl.md
Name: vedic64_seq_ctrl

Overview:
- Sequential 64x64 unsigned multiply controller.
- Time-shares one external 32x32 Vedic multiplier over four partial-product steps and accumulates the results into a 128-bit product.
- Sits between a valid/ready operand source and a valid/ready result sink. Lets area-constrained builds avoid a full combinational 64x64 array.

Parameters:
- HW, 32, half operand width; width of each external multiplier input (full operand = 2*HW).
- PIPE_LAT, 0, latency in cycles of the external multiplier: 0 = combinational product in the same cycle, N = product valid N cycles after inputs applied. Legal range 0..7.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- a_in  input  2*HW  multiplicand
- b_in  input  2*HW  multiplier
- mul_a  output  HW  operand A to external 32x32 multiplier
- mul_b  output  HW  operand B to external 32x32 multiplier
- mul_p  input  2*HW  product returned by external multiplier
- out_valid  output  1  product valid
- out_ready  input  1  sink accepts product
- product  output  4*HW  128-bit result
- busy  output  1  high from accept until result handshake completes

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: in_ready=1, out_valid=0, product=0, mul_a=0, mul_b=0, busy=0, accumulator=0, state=IDLE, wait counter=0.
- Reset is sampled on clk edge only and overrides all other activity, including mid-operation. A partially accumulated result is discarded, never emitted.
- States: IDLE, P0, P1, P2, P3, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_in/b_in into operand registers, clear accumulator, go to P0.
- Step operand and accumulation table:
  - P0: mul_a=a[HW-1:0], mul_b=b[HW-1:0]; accumulator += mul_p.
  - P1: mul_a=a[2HW-1:HW], mul_b=b[HW-1:0]; accumulator += mul_p<<HW.
  - P2: mul_a=a[HW-1:0], mul_b=b[2HW-1:HW]; accumulator += mul_p<<HW.
  - P3: mul_a=a[2HW-1:HW], mul_b=b[2HW-1:HW]; accumulator += mul_p<<2HW.
- Step timing:
  - Each Pk state holds mul_a/mul_b stable for PIPE_LAT+1 cycles, counted by a wait counter.
  - mul_p is sampled and accumulated only in the last cycle of the step. The counter resets on entry to each step.
  - mul_a/mul_b are driven from registered operands and state (no combinational path from a_in/b_in). They are 0 in IDLE and DONE.
- Accumulator rules: 4*HW bits, unsigned, no overflow possible for unsigned operands. The carry from each addition propagates across the full width.
- P3 completion: copy the final sum (including P3 term) to product, set out_valid=1, go to DONE.
- DONE:
  - product and out_valid hold stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE. product keeps its last value.
- Latency:
  - Accept edge to out_valid high = 4*(PIPE_LAT+1) cycles.
  - PIPE_LAT=0: out_valid rises on the 4th edge after the accept edge.
- Throughput: minimum of 1 bubble cycle between result handshake and next accept. in_ready=0 in P0..P3 and DONE.
- busy = (state != IDLE).
- Simultaneous events:
  - in_valid held high during DONE is ignored until IDLE.
  - out_ready asserted before out_valid has no effect.
  - a_in/b_in changes after accept do not affect the current result.

Test Plan:
- Reset then accept a=0xFFFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF, out_ready=1, PIPE_LAT=0 -> mul_a/mul_b sequence (FFFFFFFF,FFFFFFFF)x4; product=0xFFFFFFFFFFFFFFFE0000000000000001; out_valid 4 cycles after accept.
- a=0x0000000100000000, b=0x0000000100000000 -> product=0x00000000000000010000000000000000; P0 and P1 add 0, P3 adds 1<<64.
- a=0x0123456789ABCDEF, b=0xFEDCBA9876543210, out_ready=0 for 10 cycles -> product holds 0x0121FA00AD77D7422236D88FE5618CF0 and in_ready=0 throughout; after out_ready=1 for one cycle, out_valid=0 and in_ready=1 next cycle.
- Assert rst for one cycle while in P2, with a=b=0xFFFFFFFFFFFFFFFF -> next cycle: state IDLE, in_ready=1, out_valid=0, product=0, mul_a=mul_b=0; no spurious result afterwards.
- PIPE_LAT=2 with a 2-stage registered model of the multiplier, a=3, b=5 -> each step holds operands 3 cycles; product=15; out_valid 12 cycles after accept.
- Back-to-back: in_valid held high with a=0/b=7, then a=7/b=0 -> both products 0; second accept occurs exactly 1 cycle after the first result handshake; busy low only in that IDLE cycle.
